// File: rtl/axi_wr_beat_fifo_pkg.sv
// Shared types and constants for the AXI write-beat buffer.
package axi_wr_beat_fifo_pkg;

  localparam int unsigned MAX_BURST_BEATS = 256;
  localparam int unsigned WR_DATA_WIDTH   = 512;
  localparam int unsigned WR_ADDR_WIDTH   = 6;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } wr_fsm_e;

  // Default-width layout; the top rebuilds the same field order at its parameterised widths.
  typedef struct packed {
    logic [WR_DATA_WIDTH-1:0] data;
    logic [WR_ADDR_WIDTH-1:0] addr;
    logic                     first;
    logic                     last;
  } wr_beat_t;

endpackage

// File: rtl/axi_wr_beat_fifo_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; rd_data always shows the head entry.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/axi_wr_beat_fifo.sv
// AXI write-beat buffer: burst tagging, strobe masking, error flags, FWFT storage.
// Optional beat/burst statistics counters are enabled with AXI_WR_FIFO_STATS_EN.
module axi_wr_beat_fifo
  import axi_wr_beat_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WR_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [DATA_WIDTH/8-1:0]       in_strb,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          burst_done,
  output logic [7:0]                    burst_len,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  input  logic                          err_clr,
  output logic                          err_partial,
  output logic                          err_len
`ifdef AXI_WR_FIFO_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_bursts
`endif
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  first;
    logic                  last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  wr_fsm_e               state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            beat_cnt;
  logic [7:0]            beat_idx;
  logic                  push, pop, full, empty;
  logic                  forced_last, partial;
  beat_t                 wr_beat, rd_beat;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // beat_idx is the index of the beat being offered now; it becomes beat_cnt on push.
  always_comb begin
    state_next    = state;
    wr_beat.first = (state == S_IDLE);
    beat_idx      = wr_beat.first ? 8'd0 : beat_cnt + 8'd1;
    forced_last   = !in_last && (beat_idx == 8'(MAX_BURST_BEATS - 1));
    wr_beat.last  = in_last || forced_last;
    wr_beat.addr  = wr_beat.first ? in_addr : addr_q;
    partial       = !(&in_strb);
    wr_beat.data  = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      wr_beat.data[i*8 +: 8] = in_strb[i] ? in_data[i*8 +: 8] : 8'h00;
    end
    if (push) state_next = wr_beat.last ? S_IDLE : S_BURST;
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      beat_cnt    <= '0;
      burst_done  <= 1'b0;
      burst_len   <= '0;
      err_partial <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      state      <= state_next;
      burst_done <= push && wr_beat.last;
      if (push) begin
        beat_cnt <= beat_idx;
        if (wr_beat.first) addr_q <= in_addr;
        if (wr_beat.last)  burst_len <= beat_idx;
      end
      if (push && partial)          err_partial <= 1'b1;
      else if (err_clr)             err_partial <= 1'b0;
      if (push && forced_last)      err_len <= 1'b1;
      else if (err_clr)             err_len <= 1'b0;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s00_axi_aclk),
    .rst     (s00_axi_areset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_beat),
    .rd_data (rd_beat),
    .full    (full),
    .empty   (empty),
    .count   (fill)
  );

  // Stale RAM contents are hidden while the FIFO is empty.
  assign out_data  = out_valid ? rd_beat.data  : '0;
  assign out_addr  = out_valid ? rd_beat.addr  : '0;
  assign out_first = out_valid && rd_beat.first;
  assign out_last  = out_valid && rd_beat.last;

`ifdef AXI_WR_FIFO_STATS_EN
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      stat_beats  <= '0;
      stat_bursts <= '0;
    end else begin
      if (push)                 stat_beats  <= stat_beats + 32'd1;
      if (push && wr_beat.last) stat_bursts <= stat_bursts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_beat_fifo.sv
// Directed table-driven bench for axi_wr_beat_fifo plus multi-cycle corner sequences.
module tb_axi_wr_beat_fifo;

  localparam int unsigned DW    = 512;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] FULL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PART  = 64'h0000_0000_0000_FFFF;

  logic          clk = 1'b0;
  logic          areset;
  logic          in_valid, in_ready, in_last;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [63:0]   in_strb;
  logic          out_valid, out_ready, out_first, out_last;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          burst_done;
  logic [7:0]    burst_len;
  logic [4:0]    fill;
  logic          err_clr, err_partial, err_len;
`ifdef AXI_WR_FIFO_STATS_EN
  logic [31:0]   stat_beats, stat_bursts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_wr_beat_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_strb        (in_strb),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_addr       (out_addr),
    .out_first      (out_first),
    .out_last       (out_last),
    .burst_done     (burst_done),
    .burst_len      (burst_len),
    .fill           (fill),
    .err_clr        (err_clr),
    .err_partial    (err_partial),
    .err_len        (err_len)
`ifdef AXI_WR_FIFO_STATS_EN
    ,
    .stat_beats     (stat_beats),
    .stat_bursts    (stat_bursts)
`endif
  );

  typedef struct {
    logic          vld;
    logic [AW-1:0] addr;
    logic [63:0]   seed;
    logic [63:0]   strb;
    logic          last;
    logic          rdy;
    logic          clr;
    logic          e_ovalid;
    logic          e_first;
    logic          e_last;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [4:0]    e_fill;
    logic          e_done;
    logic [7:0]    e_len;
    logic          e_part;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [DW-1:0] rep(input logic [63:0] s);
    return {8{s}};
  endfunction

  function automatic logic [DW-1:0] part(input logic [63:0] s);
    return {384'h0, s, s};
  endfunction

  function automatic vec_t mk(
    input logic vld, input logic [AW-1:0] addr, input logic [63:0] seed,
    input logic [63:0] strb, input logic last, input logic rdy, input logic clr,
    input logic e_ovalid, input logic e_first, input logic e_last,
    input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data, input logic [4:0] e_fill,
    input logic e_done, input logic [7:0] e_len, input logic e_part);
    vec_t v;
    v.vld = vld; v.addr = addr; v.seed = seed; v.strb = strb; v.last = last;
    v.rdy = rdy; v.clr = clr; v.e_ovalid = e_ovalid; v.e_first = e_first;
    v.e_last = e_last; v.e_addr = e_addr; v.e_data = e_data; v.e_fill = e_fill;
    v.e_done = e_done; v.e_len = e_len; v.e_part = e_part;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic vld, input logic [AW-1:0] addr, input logic [63:0] seed,
                     input logic [63:0] strb, input logic last, input logic rdy, input logic clr);
    in_valid  = vld;
    in_addr   = addr;
    in_data   = {8{seed}};
    in_strb   = strb;
    in_last   = last;
    out_ready = rdy;
    err_clr   = clr;
  endtask

  initial begin
    vecs[0]  = mk(1, 6'h04, 64'hA1A1_0000_1234_5678, FULL, 1, 0, 0,
                  1, 1, 1, 6'h04, rep(64'hA1A1_0000_1234_5678), 5'd1, 1, 8'd0, 0);
    vecs[1]  = mk(0, 6'h00, 64'h0, FULL, 0, 1, 0,
                  0, 0, 0, 6'h00, '0, 5'd0, 0, 8'd0, 0);
    vecs[2]  = mk(1, 6'h08, 64'hB0B0_B0B0_0000_0001, FULL, 0, 1, 0,
                  1, 1, 0, 6'h08, rep(64'hB0B0_B0B0_0000_0001), 5'd1, 0, 8'd0, 0);
    vecs[3]  = mk(1, 6'h09, 64'hB1B1_B1B1_0000_0002, FULL, 0, 1, 0,
                  1, 0, 0, 6'h08, rep(64'hB1B1_B1B1_0000_0002), 5'd1, 0, 8'd0, 0);
    vecs[4]  = mk(1, 6'h0A, 64'hB2B2_B2B2_0000_0003, FULL, 0, 1, 0,
                  1, 0, 0, 6'h08, rep(64'hB2B2_B2B2_0000_0003), 5'd1, 0, 8'd0, 0);
    vecs[5]  = mk(1, 6'h0B, 64'hB3B3_B3B3_0000_0004, FULL, 1, 1, 0,
                  1, 0, 1, 6'h08, rep(64'hB3B3_B3B3_0000_0004), 5'd1, 1, 8'd3, 0);
    vecs[6]  = mk(0, 6'h00, 64'h0, FULL, 0, 1, 0,
                  0, 0, 0, 6'h00, '0, 5'd0, 0, 8'd3, 0);
    vecs[7]  = mk(1, 6'h02, 64'hC5C5_1122_3344_5566, PART, 1, 0, 0,
                  1, 1, 1, 6'h02, part(64'hC5C5_1122_3344_5566), 5'd1, 1, 8'd0, 1);
    vecs[8]  = mk(0, 6'h00, 64'h0, FULL, 0, 1, 1,
                  0, 0, 0, 6'h00, '0, 5'd0, 0, 8'd0, 0);
    vecs[9]  = mk(1, 6'h01, 64'hD7D7_8899_AABB_CCDD, PART, 1, 1, 1,
                  1, 1, 1, 6'h01, part(64'hD7D7_8899_AABB_CCDD), 5'd1, 1, 8'd0, 1);
    vecs[10] = mk(0, 6'h00, 64'h0, FULL, 0, 1, 1,
                  0, 0, 0, 6'h00, '0, 5'd0, 0, 8'd0, 0);

    areset = 1'b1;
    drv(0, '0, 64'h0, FULL, 0, 0, 0);
    @(negedge clk);
    step();
    chk("rst.in_ready",    DW'(in_ready),    DW'(1));
    chk("rst.out_valid",   DW'(out_valid),   DW'(0));
    chk("rst.out_data",    out_data,         '0);
    chk("rst.out_addr",    DW'(out_addr),    DW'(0));
    chk("rst.out_first",   DW'(out_first),   DW'(0));
    chk("rst.out_last",    DW'(out_last),    DW'(0));
    chk("rst.burst_done",  DW'(burst_done),  DW'(0));
    chk("rst.burst_len",   DW'(burst_len),   DW'(0));
    chk("rst.fill",        DW'(fill),        DW'(0));
    chk("rst.err_partial", DW'(err_partial), DW'(0));
    chk("rst.err_len",     DW'(err_len),     DW'(0));
    areset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drv(vecs[i].vld, vecs[i].addr, vecs[i].seed, vecs[i].strb, vecs[i].last,
          vecs[i].rdy, vecs[i].clr);
      step();
      chk($sformatf("v%0d.out_valid", i),   DW'(out_valid),   DW'(vecs[i].e_ovalid));
      chk($sformatf("v%0d.out_first", i),   DW'(out_first),   DW'(vecs[i].e_first));
      chk($sformatf("v%0d.out_last", i),    DW'(out_last),    DW'(vecs[i].e_last));
      chk($sformatf("v%0d.out_addr", i),    DW'(out_addr),    DW'(vecs[i].e_addr));
      chk($sformatf("v%0d.out_data", i),    out_data,         vecs[i].e_data);
      chk($sformatf("v%0d.fill", i),        DW'(fill),        DW'(vecs[i].e_fill));
      chk($sformatf("v%0d.burst_done", i),  DW'(burst_done),  DW'(vecs[i].e_done));
      chk($sformatf("v%0d.burst_len", i),   DW'(burst_len),   DW'(vecs[i].e_len));
      chk($sformatf("v%0d.err_partial", i), DW'(err_partial), DW'(vecs[i].e_part));
      chk($sformatf("v%0d.in_ready", i),    DW'(in_ready),    DW'(1));
      chk($sformatf("v%0d.err_len", i),     DW'(err_len),     DW'(0));
    end

    // Fill to full with the consumer stalled, then release it for a single cycle.
    for (int i = 0; i < 16; i++) begin
      drv(1, AW'(i), 64'(i), FULL, 1, 0, 0);
      step();
    end
    chk("full.in_ready", DW'(in_ready), DW'(0));
    chk("full.fill",     DW'(fill),     DW'(16));
    chk("full.head",     DW'(out_addr), DW'(0));
    drv(1, 6'h3F, 64'hDEAD, FULL, 1, 1, 0);
    step();
    chk("full.pop_fill",     DW'(fill),     DW'(15));
    chk("full.pop_in_ready", DW'(in_ready), DW'(1));
    drv(0, '0, 64'h0, FULL, 0, 1, 0);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("drain%0d.addr", k),  DW'(out_addr),  DW'(k));
      chk($sformatf("drain%0d.data", k),  out_data,       rep(64'(k)));
      step();
    end
    chk("drain.empty", DW'(out_valid), DW'(0));

    // 257 beats without WLAST at full throughput.
    for (int k = 1; k <= 257; k++) begin
      drv(1, (k == 1) ? 6'h10 : (k == 257) ? 6'h20 : 6'h3F, 64'(k), FULL, 0, 1, 0);
      step();
      if (k == 1) begin
        chk("long1.first", DW'(out_first), DW'(1));
        chk("long1.addr",  DW'(out_addr),  DW'(6'h10));
      end
      if (k == 2) begin
        chk("long2.first", DW'(out_first), DW'(0));
        chk("long2.addr",  DW'(out_addr),  DW'(6'h10));
      end
      if (k == 255) begin
        chk("long255.last",    DW'(out_last), DW'(0));
        chk("long255.err_len", DW'(err_len),  DW'(0));
      end
      if (k == 256) begin
        chk("long256.last",       DW'(out_last),   DW'(1));
        chk("long256.addr",       DW'(out_addr),   DW'(6'h10));
        chk("long256.err_len",    DW'(err_len),    DW'(1));
        chk("long256.burst_done", DW'(burst_done), DW'(1));
        chk("long256.burst_len",  DW'(burst_len),  DW'(255));
        chk("long256.fill",       DW'(fill),       DW'(1));
      end
      if (k == 257) begin
        chk("long257.first",   DW'(out_first), DW'(1));
        chk("long257.addr",    DW'(out_addr),  DW'(6'h20));
        chk("long257.last",    DW'(out_last),  DW'(0));
        chk("long257.err_len", DW'(err_len),   DW'(1));
        chk("long257.done",    DW'(burst_done), DW'(0));
      end
    end
    drv(1, 6'h3F, 64'h0, FULL, 1, 1, 0);
    step();
    chk("long_end.burst_len", DW'(burst_len), DW'(1));
    chk("long_end.addr",      DW'(out_addr),  DW'(6'h20));
    drv(0, '0, 64'h0, FULL, 0, 1, 1);
    step();
    chk("long_clr.err_len", DW'(err_len), DW'(0));
    chk("long_clr.fill",    DW'(fill),    DW'(0));

    // Reset in the middle of a buffered burst.
    for (int i = 0; i < 5; i++) begin
      drv(1, 6'h03, 64'(i), FULL, 0, 0, 0);
      step();
    end
    chk("mid.fill", DW'(fill), DW'(5));
    drv(0, '0, 64'h0, FULL, 0, 0, 0);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("mid_rst.fill",      DW'(fill),      DW'(0));
    chk("mid_rst.out_valid", DW'(out_valid), DW'(0));
    chk("mid_rst.in_ready",  DW'(in_ready),  DW'(1));
    drv(1, 6'h07, 64'h77, FULL, 0, 0, 0);
    step();
    chk("post_rst.first", DW'(out_first), DW'(1));
    chk("post_rst.addr",  DW'(out_addr),  DW'(6'h07));
    chk("post_rst.fill",  DW'(fill),      DW'(1));
    drv(1, 6'h09, 64'h78, FULL, 1, 0, 0);
    step();
    chk("post_rst.burst_len", DW'(burst_len), DW'(1));
    chk("post_rst.fill2",     DW'(fill),      DW'(2));
    drv(0, '0, 64'h0, FULL, 0, 1, 0);
    step();
    chk("post_rst.head2_addr", DW'(out_addr), DW'(6'h07));
    chk("post_rst.head2_last", DW'(out_last), DW'(1));
    step();
    chk("post_rst.drained", DW'(out_valid), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_beat_fifo.md
# axi_wr_beat_fifo

Write-beat buffer directly downstream of the AXI4 slave write path. It accepts each accepted W-channel beat together with its burst address. It tags each beat with burst-first and burst-last markers and buffers it in a first-word-fall-through FIFO. It then presents the beats to the Benes permutation input stage under valid/ready flow control, reporting burst completion, length and protocol errors.

## Interface
Parameters:
- DATA_WIDTH, 512, beat width in bits (multiple of 8)
- ADDR_WIDTH, 6, burst start address width
- FIFO_DEPTH, 16, entries; power of 2, ≥2

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  reset; **synchronous, active-high**, one clock domain
- in_valid  in  1  beat offered by slave write path
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_addr  in  ADDR_WIDTH  burst start address; sampled on first beat only
- in_data  in  DATA_WIDTH  beat data
- in_strb  in  DATA_WIDTH/8  byte strobes
- in_last  in  1  AXI WLAST
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_data  out  DATA_WIDTH  strobe-masked data
- out_addr  out  ADDR_WIDTH  burst start address of the entry
- out_first  out  1  first beat of burst
- out_last  out  1  last beat of burst (WLAST or forced)
- burst_done  out  1  one-cycle pulse when a last beat is pushed
- burst_len  out  8  beats−1 of most recently completed burst
- fill  out  $clog2(FIFO_DEPTH)+1  current occupancy
- err_clr  in  1  clears sticky error flags
- err_partial  out  1  sticky: beat pushed with in_strb not all-ones
- err_len  out  1  sticky: burst exceeded 256 beats

## Operation
- Input FSM has two states: S_IDLE (next beat is first) and S_BURST.
  - S_IDLE: on push, latch in_addr into addr_q, set beat_cnt=0, tag first=1. Stay in S_IDLE if in_last, else go to S_BURST.
  - S_BURST: on push, tag first=0, use addr_q, and beat_cnt++. Return to S_IDLE on in_last.
  - Forced last: if beat_cnt==255 on a push without in_last, the beat is tagged last=1, err_len is set and the FSM returns to S_IDLE.
- Data masking: byte i of stored data = in_strb[i] ? in_data byte i : 8'h00. Any zero strobe bit sets err_partial.
- On pushing a last-tagged beat: burst_done=1 in the next cycle and burst_len=beat_cnt. burst_len holds until the next burst completes.
- FIFO:
  - in_ready = (fill != FIFO_DEPTH), registered-equivalent. It does not depend on out_ready, so there is no full-pass-through.
  - Output is FWFT: out_* show the entry at rd_ptr whenever fill>0.
- Simultaneous push and pop: fill is unchanged and both pointers advance.
- Pop on empty and push on full are impossible by handshake.
- Pointers wrap modulo FIFO_DEPTH.
- err_clr and a new error in the same cycle: the error wins and the flag stays 1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data/out_addr/out_first/out_last=0, burst_done=0, burst_len=0, fill=0, err_partial=0, err_len=0, FSM=S_IDLE.
- Reset mid-burst discards all buffered and partial beats. The next accepted beat is treated as a first beat.
- Latency: push at edge N → out_valid=1 after edge N (1 cycle). No same-cycle bypass.
- Throughput: 1 beat/cycle sustained when out_ready=1 constantly.
- fill updates on the same edge as the handshake.
- Downstream is required to hold out_ready independent of out_valid or not; there is no combinational path from out_ready to in_ready.

## Configuration
- AXI_WR_FIFO_STATS_EN defined: adds two ports.
  - stat_beats (out, 32): counts every push, wraps at 2^32.
  - stat_bursts (out, 32): counts every last-tagged push, wraps at 2^32.
  - Both are cleared by s00_axi_areset only.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- USER_PKG holds:
  - wr_beat_t struct {data, addr, first, last}
  - wr_fsm_e enum {S_IDLE, S_BURST}
  - MAX_BURST_BEATS=256
- Sub-module sync_fifo_fwft (parameters WIDTH and DEPTH; ports push/pop/full/empty/count) stores packed wr_beat_t. The top level keeps the FSM, masking, tagging and flags.

## Test plan
- Single-beat burst: addr=6'h04, last=1, strb all-ones → out_first=1, out_last=1, out_addr=4 after 1 cycle; burst_done pulse; burst_len=0.
- 4-beat burst, out_ready=1: beats tagged first,0,0,last; all carry the first beat's address. Changing in_addr on beats 2–4 has no effect; burst_len=3.
- Fill with out_ready=0: after 16 pushes, in_ready=0 and fill=16. Then set out_ready=1 for one cycle with in_valid=1: no push that cycle, fill=15, then in_ready=1.
- in_strb=64'h00000000_0000FFFF → only the low 16 bytes pass and the rest read 0; err_partial=1. err_clr pulse → err_partial=0.
- 257 beats without WLAST: beat 256 is tagged last and err_len=1. Beat 257 is tagged first.
- Reset asserted mid-burst with fill=5 → next cycle fill=0, out_valid=0. The next beat is tagged first with its own address.
